// File: rtl/modport_fifo.sv
// modport_fifo: single-clock 32x32 FIFO with write-side status,
// soft/memory clears and a minimal registered read port.
module modport_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  wclk,
   input  logic                  hw_rst_n,
   input  logic                  mem_rst,
   input  logic                  sw_rst,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  write_enable,
   input  logic [ADDR_WIDTH-1:0] afull_value,
   input  logic                  read_enable,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rempty,
   output logic                  underflow,
   output logic                  wfull,
   output logic                  wr_almost_ful,
   output logic                  overflow,
   output logic [ADDR_WIDTH:0]   fifo_write_count,
   output logic [ADDR_WIDTH:0]   wr_level
);

   localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

   logic                  rst_q;
   logic [ADDR_WIDTH:0]   wptr;
   logic [ADDR_WIDTH:0]   rptr;
   logic [ADDR_WIDTH:0]   count;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  full;
   logic                  empty;
   logic                  wr_acc;
   logic                  rd_acc;

   // Assert immediately, release one edge later so the first
   // write lands on the second edge after hw_rst_n rises.
   always_ff @(posedge wclk or negedge hw_rst_n) begin
      if (!hw_rst_n) rst_q <= 1'b0;
      else           rst_q <= 1'b1;
   end

   assign count  = wptr - rptr;
   assign full   = (count == FULL_CNT);
   assign empty  = (count == '0);
   assign rd_acc = read_enable && !empty && !sw_rst;
   assign wr_acc = write_enable && !sw_rst && !mem_rst
                   && (!full || read_enable);

   always_ff @(posedge wclk or negedge rst_q) begin
      if (!rst_q) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (mem_rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_acc) begin
         mem[wptr[ADDR_WIDTH-1:0]] <= wdata;
      end
   end

   always_ff @(posedge wclk or negedge rst_q) begin
      if (!rst_q) begin
         wptr <= '0;
         rptr <= '0;
      end else if (sw_rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_acc) wptr <= wptr + 1'b1;
         if (rd_acc) rptr <= rptr + 1'b1;
      end
   end

   // A read coinciding with a memory clear returns the cleared value.
   always_ff @(posedge wclk or negedge rst_q) begin
      if (!rst_q) begin
         rdata <= '0;
      end else if (sw_rst) begin
         rdata <= '0;
      end else if (rd_acc) begin
         rdata <= mem_rst ? '0 : mem[rptr[ADDR_WIDTH-1:0]];
      end
   end

   always_ff @(posedge wclk or negedge rst_q) begin
      if (!rst_q) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (sw_rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= write_enable && full && !read_enable;
         underflow <= read_enable && empty;
      end
   end

   assign wfull            = full;
   assign rempty           = empty;
   assign fifo_write_count = count;
   assign wr_level         = FULL_CNT - count;
   assign wr_almost_ful    = (count >= {1'b0, afull_value});

endmodule

// File: tb/tb_modport_fifo.sv
// tb_modport_fifo: vector table, corner sequences and random
// traffic against a queue-based reference model.
module tb_modport_fifo;

   logic        wclk = 1'b0;
   logic        hw_rst_n;
   logic        mem_rst;
   logic        sw_rst;
   logic [31:0] wdata;
   logic        write_enable;
   logic [4:0]  afull_value;
   logic        read_enable;
   logic [31:0] rdata;
   logic        rempty;
   logic        underflow;
   logic        wfull;
   logic        wr_almost_ful;
   logic        overflow;
   logic [5:0]  fifo_write_count;
   logic [5:0]  wr_level;

   int checks   = 0;
   int failures = 0;

   logic [31:0] q[$];
   logic [31:0] m_rdata;
   logic        m_ovf;
   logic        m_unf;

   always #5 wclk = ~wclk;

   modport_fifo dut (
      .wclk             (wclk),
      .hw_rst_n         (hw_rst_n),
      .mem_rst          (mem_rst),
      .sw_rst           (sw_rst),
      .wdata            (wdata),
      .write_enable     (write_enable),
      .afull_value      (afull_value),
      .read_enable      (read_enable),
      .rdata            (rdata),
      .rempty           (rempty),
      .underflow        (underflow),
      .wfull            (wfull),
      .wr_almost_ful    (wr_almost_ful),
      .overflow         (overflow),
      .fifo_write_count (fifo_write_count),
      .wr_level         (wr_level)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_model(input string tag);
      int n;
      n = q.size();
      chk({tag, " count"}, 32'(fifo_write_count), 32'(n));
      chk({tag, " level"}, 32'(wr_level), 32'(32 - n));
      chk({tag, " full"}, 32'(wfull), 32'(n == 32));
      chk({tag, " empty"}, 32'(rempty), 32'(n == 0));
      chk({tag, " afull"}, 32'(wr_almost_ful),
          32'(n >= int'(afull_value)));
      chk({tag, " ovf"}, 32'(overflow), 32'(m_ovf));
      chk({tag, " unf"}, 32'(underflow), 32'(m_unf));
      chk({tag, " rdata"}, rdata, m_rdata);
   endtask

   task automatic model_edge(input logic we, input logic re,
                             input logic sw, input logic mr,
                             input logic [31:0] wd);
      int  n;
      bit  fl, em;
      n  = q.size();
      fl = (n == 32);
      em = (n == 0);
      if (sw) begin
         q.delete();
         m_ovf   = 1'b0;
         m_unf   = 1'b0;
         m_rdata = '0;
      end else begin
         m_ovf = we && fl && !re;
         m_unf = re && em;
         if (re && !em) begin
            m_rdata = q.pop_front();
            if (mr) m_rdata = '0;
         end
         if (mr) foreach (q[i]) q[i] = '0;
         if (we && !mr && (!fl || re)) q.push_back(wd);
      end
   endtask

   task automatic step(input string tag, input logic we,
                       input logic re, input logic sw,
                       input logic mr, input logic [31:0] wd,
                       input logic [4:0] afv);
      @(negedge wclk);
      write_enable = we;
      read_enable  = re;
      sw_rst       = sw;
      mem_rst      = mr;
      wdata        = wd;
      afull_value  = afv;
      @(posedge wclk);
      #1;
      model_edge(we, re, sw, mr, wd);
      check_model(tag);
   endtask

   task automatic model_reset();
      q.delete();
      m_rdata = '0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
   endtask

   typedef struct {
      logic        we;
      logic        re;
      logic        sw;
      logic        mr;
      logic [31:0] wd;
      logic [4:0]  afv;
      int          cnt;
      logic        af;
      logic        unf;
      logic [31:0] rd;
   } vec_t;

   vec_t tbl[12];

   initial begin
      tbl[0]  = '{0, 1, 0, 0, 32'h0,        1, 0, 0, 1, 32'h0};
      tbl[1]  = '{1, 1, 0, 0, 32'hA5A50001, 1, 1, 1, 1, 32'h0};
      tbl[2]  = '{0, 0, 0, 0, 32'h0,        1, 1, 1, 0, 32'h0};
      tbl[3]  = '{0, 1, 0, 0, 32'h0,        1, 0, 0, 0, 32'hA5A50001};
      tbl[4]  = '{1, 0, 0, 0, 32'hA5A50002, 1, 1, 1, 0, 32'hA5A50001};
      tbl[5]  = '{1, 0, 0, 0, 32'hA5A50003, 1, 2, 1, 0, 32'hA5A50001};
      tbl[6]  = '{1, 0, 0, 1, 32'hA5A50004, 1, 2, 1, 0, 32'hA5A50001};
      tbl[7]  = '{0, 1, 0, 0, 32'h0,        1, 1, 1, 0, 32'h0};
      tbl[8]  = '{1, 1, 0, 0, 32'hA5A50005, 1, 1, 1, 0, 32'h0};
      tbl[9]  = '{0, 1, 0, 0, 32'h0,        1, 0, 0, 0, 32'hA5A50005};
      tbl[10] = '{1, 1, 1, 0, 32'hA5A50006, 1, 0, 0, 0, 32'h0};
      tbl[11] = '{0, 0, 0, 0, 32'h0,        0, 0, 1, 0, 32'h0};

      hw_rst_n     = 1'b0;
      mem_rst      = 1'b0;
      sw_rst       = 1'b0;
      wdata        = '0;
      write_enable = 1'b0;
      read_enable  = 1'b0;
      afull_value  = '0;
      model_reset();
      #12;
      check_model("por");

      // first edge after release is absorbed by the synchroniser
      @(negedge wclk);
      hw_rst_n     = 1'b1;
      write_enable = 1'b1;
      wdata        = 32'h77;
      @(posedge wclk);
      #1;
      chk("release_edge1 count", 32'(fifo_write_count), 32'd0);
      step("release_edge2", 1, 0, 0, 0, 32'h77, 0);
      chk("release_edge2 count", 32'(fifo_write_count), 32'd1);

      step("clr", 0, 0, 1, 0, 0, 1);
      foreach (tbl[i]) begin
         step($sformatf("vec%0d", i), tbl[i].we, tbl[i].re,
              tbl[i].sw, tbl[i].mr, tbl[i].wd, tbl[i].afv);
         chk($sformatf("tbl%0d cnt", i), 32'(fifo_write_count),
             32'(tbl[i].cnt));
         chk($sformatf("tbl%0d af", i), 32'(wr_almost_ful),
             32'(tbl[i].af));
         chk($sformatf("tbl%0d unf", i), 32'(underflow),
             32'(tbl[i].unf));
         chk($sformatf("tbl%0d rd", i), rdata, tbl[i].rd);
      end

      // fill, almost-full at 28, full at 32
      for (int i = 0; i < 32; i++) begin
         step("fill", 1, 0, 0, 0, 32'(i), 28);
         chk($sformatf("fill%0d af", i), 32'(wr_almost_ful),
             32'(i >= 27));
         chk($sformatf("fill%0d full", i), 32'(wfull),
             32'(i == 31));
      end
      chk("full level", 32'(wr_level), 32'd0);
      step("ovf", 1, 0, 0, 0, 32'hDEAD, 28);
      chk("ovf pulse", 32'(overflow), 32'd1);
      chk("ovf count", 32'(fifo_write_count), 32'd32);
      step("ovf_clr", 0, 0, 0, 0, 0, 28);
      chk("ovf one cycle", 32'(overflow), 32'd0);
      step("full_rw", 1, 1, 0, 0, 32'h100, 28);
      chk("full_rw count", 32'(fifo_write_count), 32'd32);
      chk("full_rw ovf", 32'(overflow), 32'd0);
      chk("full_rw rdata", rdata, 32'h0);
      for (int i = 1; i <= 32; i++) begin
         step("drain", 0, 1, 0, 0, 0, 28);
         chk($sformatf("drain%0d", i), rdata,
             (i == 32) ? 32'h100 : 32'(i));
      end
      step("empty_rw", 1, 1, 0, 0, 32'h55, 28);
      chk("empty_rw count", 32'(fifo_write_count), 32'd1);
      chk("empty_rw unf", 32'(underflow), 32'd1);
      step("unf_clr", 0, 0, 0, 0, 0, 28);

      // wrap with interleaved reads
      for (int i = 0; i < 40; i++) begin
         step("wrap", 1, (i % 2) == 1, 0, 0, 32'h200 + 32'(i), 20);
      end

      step("pre_sw", 0, 0, 1, 0, 0, 5);
      for (int i = 0; i < 10; i++) step("ten", 1, 0, 0, 0, 32'(i), 5);
      step("sw", 0, 0, 1, 0, 0, 5);
      chk("sw count", 32'(fifo_write_count), 32'd0);
      chk("sw level", 32'(wr_level), 32'd32);
      chk("sw empty", 32'(rempty), 32'd1);

      for (int i = 0; i < 3; i++) step("mr_w", 1, 0, 0, 0, 32'hF0 + 32'(i), 5);
      step("mr", 0, 0, 0, 1, 0, 5);
      step("mr_r", 0, 1, 0, 0, 0, 5);
      chk("mr read zero", rdata, 32'h0);

      // random traffic, alternating write-heavy and read-heavy phases
      for (int i = 0; i < 3000; i++) begin
         int  wp;
         logic we, re, sw, mr;
         wp = ((i / 150) % 2 == 0) ? 70 : 30;
         we = ($urandom_range(0, 99) < wp);
         re = ($urandom_range(0, 99) < (100 - wp));
         sw = ($urandom_range(0, 299) == 0);
         mr = ($urandom_range(0, 299) == 0);
         step("rnd", we, re, sw, mr, $urandom,
              5'($urandom_range(0, 31)));
      end

      // asynchronous reset mid-stream
      for (int i = 0; i < 6; i++) step("pre_hw", 1, 0, 0, 0, 32'(i), 0);
      @(negedge wclk);
      #2;
      hw_rst_n = 1'b0;
      #1;
      model_reset();
      check_model("hw_rst");
      write_enable = 1'b1;
      @(posedge wclk);
      #1;
      check_model("hw_rst_hold");
      @(negedge wclk);
      hw_rst_n     = 1'b1;
      write_enable = 1'b0;
      step("post_hw0", 0, 0, 0, 0, 0, 0);
      step("post_hw1", 1, 0, 0, 0, 32'h99, 0);
      step("post_hw2", 0, 1, 0, 0, 0, 0);
      chk("post_hw read", rdata, 32'h99);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
